nv_nvdla_sdp2pdp_buf: RTL and testbench
=======================================

// Module: nv_nvdla_sdp2pdp_buf
// PURPOSE
//  Elastic buffer on the SDP->PDP output stream, between the SDP partition's sdp2pdp_* port and PDP.
//  Decouples SDP back-pressure from PDP stalls and keeps the sdp2pdp_ready path free of any
//  combinational dependency on PDP ready.
//  Holds up to DEPTH beats; reports fill level and saturating transfer/stall performance counters.
// PARAMETERS
//  DW     128  payload width; equals the SDP->PDP pd width (16 elem x 8b)
//  DEPTH  4    capacity in beats; power of two, >=2
//  LW     3    fill-level width = clog2(DEPTH+1)
// PORTS
//  nvdla_core_clk   in   1   core clock
//  nvdla_core_rstn  in   1   async active-low reset
//  sdp2pdp_valid    in   1   upstream beat valid
//  sdp2pdp_ready    out  1   upstream accept
//  sdp2pdp_pd       in   DW  upstream payload
//  pdp_sdp_valid    out  1   downstream beat valid
//  pdp_sdp_ready    in   1   downstream accept
//  pdp_sdp_pd       out  DW  downstream payload
//  perf_en          in   1   enables counting
//  perf_clr         in   1   sync clear of both perf counters
//  buf_lvl          out  LW  beats currently held
//  perf_xfer_cnt    out  32  beats delivered downstream, saturating
//  perf_stall_cnt   out  32  cycles with pdp_sdp_valid & !pdp_sdp_ready, saturating
// BEHAVIOUR
//  Clocking/reset
//  - Single clock nvdla_core_clk.
//  - nvdla_core_rstn is asynchronous and active-low.
//  - Reset values: pdp_sdp_valid=0, pdp_sdp_pd=0, buf_lvl=0, both perf counters=0,
//    rd/wr pointers=0; sdp2pdp_ready=1 once reset deasserts.
//  - Reset mid-operation discards all held beats; no partial beat is ever emitted.
//  Handshake
//  - push = sdp2pdp_valid & sdp2pdp_ready; pop = pdp_sdp_valid & pdp_sdp_ready.
//  - sdp2pdp_ready = (buf_lvl != DEPTH); a function of registered state only, never of pdp_sdp_ready.
//  - pdp_sdp_valid = (buf_lvl != 0), registered; pdp_sdp_pd is the head beat from a register.
//  - Once valid is high, pdp_sdp_pd holds stable until pop.
//  - Beats leave in arrival order; no loss, no duplication.
//  - Latency: a beat pushed into an empty buffer in cycle N appears on pdp_sdp_* in cycle N+1.
//  - Zero-cycle bypass is forbidden.
//  Boundary conditions
//  - Full (lvl==DEPTH): ready=0. A pop in that cycle lowers lvl to DEPTH-1 and raises ready next cycle.
//    No push in that same cycle.
//  - Empty: pop is impossible (valid=0).
//  - Push and pop in the same cycle: lvl unchanged; head advances and tail writes.
//  - Push and pop when lvl==1: the new beat becomes the head next cycle and valid stays 1.
//  - Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//  - buf_lvl += push - pop, range 0..DEPTH.
//  Perf counters
//  - perf_xfer_cnt increments on pop when perf_en=1.
//  - perf_stall_cnt increments when pdp_sdp_valid & !pdp_sdp_ready and perf_en=1.
//  - Both counters saturate at 32'hFFFF_FFFF and hold there.
//  - perf_clr has priority: counters read 0 the cycle after perf_clr, even if an increment
//    coincides with the clear.
//  - perf_en and perf_clr have no effect on the datapath.
// TESTING
//  1. Push 4 beats 0x..01..0x..04 with pdp_sdp_ready=0 -> lvl=4, sdp2pdp_ready=0 from the cycle after
//     the 4th push; stall_cnt counts 1/cycle. Then ready=1 -> beats exit 01,02,03,04 on consecutive
//     cycles; xfer_cnt=4.
//  2. Continuous valid on both sides, 100 beats of incrementing data -> 1 beat/cycle after 1-cycle
//     fill, lvl stays 1, all 100 beats in order, stall_cnt=0.
//  3. Full (lvl=4) with simultaneous upstream valid and downstream pop -> no push that cycle; lvl=3;
//     ready=1 next cycle; the pending upstream beat is accepted then.
//  4. Assert nvdla_core_rstn low with lvl=3 -> valid=0, lvl=0, pd=0 immediately (async).
//     After release, ready=1 and no stale beat is emitted.
//  5. Preload stall_cnt to 32'hFFFF_FFFE via force, hold stall 3 cycles -> reads FFFF_FFFF and holds.
//     perf_clr with a concurrent stall -> 0 next cycle.
//  6. Random valid/ready at 30%/70% duty, 10k beats, scoreboard -> in-order and lossless;
//     sdp2pdp_ready never depends on same-cycle pdp_sdp_ready (checked by assertion).

Source files
------------

// File: rtl/nv_nvdla_sdp2pdp_buf.sv
// Elastic buffer on the SDP->PDP output stream.
// Upstream ready is derived from registered fill level only, so the ready path never sees
// pdp_sdp_ready. The head beat is always taken from storage, never bypassed from the input,
// so a beat pushed into an empty buffer appears on the output one cycle later.
module nv_nvdla_sdp2pdp_buf #(
  parameter int unsigned DW    = 128,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          sdp2pdp_valid,
  output logic          sdp2pdp_ready,
  input  logic [DW-1:0] sdp2pdp_pd,
  output logic          pdp_sdp_valid,
  input  logic          pdp_sdp_ready,
  output logic [DW-1:0] pdp_sdp_pd,
  input  logic          perf_en,
  input  logic          perf_clr,
  output logic [LW-1:0] buf_lvl,
  output logic [31:0]   perf_xfer_cnt,
  output logic [31:0]   perf_stall_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          valid_q;
  logic [31:0]   perf_xfer_cnt_q, perf_xfer_cnt_d;
  logic [31:0]   perf_stall_cnt_q, perf_stall_cnt_d;
  logic          push, pop;

  assign sdp2pdp_ready  = (lvl_q != LW'(DEPTH));
  assign push           = sdp2pdp_valid & sdp2pdp_ready;
  assign pop            = valid_q & pdp_sdp_ready;
  assign pdp_sdp_valid  = valid_q;
  assign pdp_sdp_pd     = mem_q[rd_ptr_q];
  assign buf_lvl        = lvl_q;
  assign perf_xfer_cnt  = perf_xfer_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;

  // Fill level next state: += push - pop.
  always_comb begin
    lvl_d = lvl_q;
    unique case ({push, pop})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  // Storage, pointers and registered valid; pointers wrap naturally at DEPTH.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      lvl_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= sdp2pdp_pd;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      lvl_q   <= lvl_d;
      valid_q <= (lvl_d != '0);
    end
  end

  // Saturating perf counters; clear wins over a coincident increment.
  always_comb begin
    perf_xfer_cnt_d  = perf_xfer_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (perf_clr) begin
      perf_xfer_cnt_d  = '0;
      perf_stall_cnt_d = '0;
    end else if (perf_en) begin
      if (pop && (perf_xfer_cnt_q != '1)) begin
        perf_xfer_cnt_d = perf_xfer_cnt_q + 32'd1;
      end
      if (valid_q && !pdp_sdp_ready && (perf_stall_cnt_q != '1)) begin
        perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
      end
    end
  end

  // Perf counter registers.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      perf_xfer_cnt_q  <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_xfer_cnt_q  <= perf_xfer_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_sdp2pdp_buf.sv
// Directed and random bench for the SDP->PDP elastic buffer.
module tb_nv_nvdla_sdp2pdp_buf;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rstn;
  logic          sv;
  logic          sr;
  logic [DW-1:0] spd;
  logic          pv;
  logic          pr;
  logic [DW-1:0] ppd;
  logic          perf_en;
  logic          perf_clr;
  logic [2:0]    lvl;
  logic [31:0]   xfer;
  logic [31:0]   stall;

  int total = 0;
  int bad   = 0;

  nv_nvdla_sdp2pdp_buf dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .sdp2pdp_valid  (sv),
    .sdp2pdp_ready  (sr),
    .sdp2pdp_pd     (spd),
    .pdp_sdp_valid  (pv),
    .pdp_sdp_ready  (pr),
    .pdp_sdp_pd     (ppd),
    .perf_en        (perf_en),
    .perf_clr       (perf_clr),
    .buf_lvl        (lvl),
    .perf_xfer_cnt  (xfer),
    .perf_stall_cnt (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       sv;
    logic [7:0] spd;
    logic       pr;
    logic       ev;
    logic [7:0] epd;
    logic [2:0] elvl;
    logic       esr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_stall;
    int exp_xfer;
    int sent;
    int rcv;
    int cyc;
    logic [DW-1:0] q[$];
    logic          sr_a;
    logic          pending;
    logic          push;
    logic          pop;

    rstn = 1'b0; sv = 1'b0; spd = '0; pr = 1'b0; perf_en = 1'b1; perf_clr = 1'b0;

    // Fill, full with pending upstream beat, drain, push+pop at lvl 1.
    vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
    vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 3'd1, 1'b1};
    vecs[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 3'd2, 1'b1};
    vecs[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 3'd3, 1'b1};
    vecs[4]  = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0};
    vecs[5]  = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h01, 3'd4, 1'b0};
    vecs[6]  = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h02, 3'd3, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 3'd4, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 3'd3, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1};
    vecs[10] = '{1'b1, 8'h06, 1'b1, 1'b1, 8'h05, 3'd1, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 3'd1, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};

    #12;
    check("rst valid", DW'(pv), DW'(0));
    check("rst lvl", DW'(lvl), DW'(0));
    check("rst pd", ppd, '0);
    check("rst xfer", DW'(xfer), DW'(0));
    check("rst stall", DW'(stall), DW'(0));
    @(negedge clk);
    rstn = 1'b1;
    check("rst ready", DW'(sr), DW'(1));

    // Table-driven directed vectors.
    exp_stall = 0;
    exp_xfer  = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      sv  = vecs[i].sv;
      spd = {16{vecs[i].spd}};
      pr  = vecs[i].pr;
      check($sformatf("vec%0d valid", i), DW'(pv), DW'(vecs[i].ev));
      if (vecs[i].ev) check($sformatf("vec%0d pd", i), ppd, {16{vecs[i].epd}});
      check($sformatf("vec%0d lvl", i), DW'(lvl), DW'(vecs[i].elvl));
      check($sformatf("vec%0d ready", i), DW'(sr), DW'(vecs[i].esr));
      if (vecs[i].ev && !vecs[i].pr) exp_stall++;
      if (vecs[i].ev && vecs[i].pr) exp_xfer++;
    end
    @(negedge clk);
    sv = 1'b0; pr = 1'b0;
    check("vec stall_cnt", DW'(stall), DW'(exp_stall));
    check("vec xfer_cnt", DW'(xfer), DW'(exp_xfer));

    // Streaming: 100 beats, one per cycle after a one-cycle fill.
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 100 && cyc < 300) begin
      sv  = (sent < 100);
      spd = DW'(sent);
      pr  = 1'b1;
      if (pv) begin
        check("stream pd", ppd, DW'(rcv));
        rcv++;
      end
      check("stream lvl<=1", DW'(lvl <= 3'd1), DW'(1));
      if (sv && sr) sent++;
      cyc++;
      @(negedge clk);
    end
    sv = 1'b0;
    check("stream cycles", DW'(cyc), DW'(101));
    check("stream stall_cnt", DW'(stall), DW'(0));
    check("stream xfer_cnt", DW'(xfer), DW'(100));

    // Async reset with three beats held.
    pr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sv = 1'b1; spd = {16{8'hA0 + 8'(i)}};
      @(negedge clk);
    end
    sv = 1'b0;
    check("prerst lvl", DW'(lvl), DW'(3));
    #2 rstn = 1'b0;
    #1;
    check("async valid", DW'(pv), DW'(0));
    check("async lvl", DW'(lvl), DW'(0));
    check("async pd", ppd, '0);
    @(negedge clk);
    rstn = 1'b1;
    check("postrst ready", DW'(sr), DW'(1));
    pr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst no stale", DW'(pv), DW'(0));
    end

    // Stall counter saturation and clear priority.
    pr = 1'b0; sv = 1'b1; spd = {16{8'h77}};
    @(negedge clk);
    sv = 1'b0;
    force dut.perf_stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.perf_stall_cnt_q;
    @(negedge clk);
    check("sat reach", DW'(stall), DW'(32'hFFFF_FFFF));
    @(negedge clk);
    @(negedge clk);
    check("sat hold", DW'(stall), DW'(32'hFFFF_FFFF));
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    check("clr prio", DW'(stall), DW'(0));
    pr = 1'b1;
    @(negedge clk);
    check("sat drain", DW'(pv), DW'(0));

    // Random 30% valid / 70% ready with scoreboard.
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    sent = 0; rcv = 0; cyc = 0; pending = 1'b0;
    while (rcv < 10000 && cyc < 60000) begin
      @(negedge clk);
      if (!pending) begin
        sv  = (sent < 10000) && ($urandom_range(0, 99) < 30);
        spd = {$urandom, $urandom, $urandom, $urandom};
      end
      pr = ($urandom_range(0, 99) < 70);
      check("rnd lvl", DW'(lvl), DW'(q.size()));
      check("rnd ready", DW'(sr), DW'(q.size() != 4));
      check("rnd valid", DW'(pv), DW'(q.size() != 0));
      if (q.size() != 0) check("rnd pd", ppd, q[0]);
      sr_a = sr;
      pr = ~pr;
      #1;
      check("rnd ready indep", DW'(sr), DW'(sr_a));
      pr = ~pr;
      #1;
      push = sv && sr;
      pop  = pv && pr;
      if (pop) begin
        void'(q.pop_front());
        rcv++;
      end
      if (push) begin
        q.push_back(spd);
        sent++;
      end
      pending = sv && !push;
      cyc++;
    end
    check("rnd all received", DW'(rcv), DW'(10000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
